// File: rtl/bcd_seq_pkg.sv
// Shared constants for the BCD sequence sender: FSM state encoding, the
// largest legal BCD digit and helpers that size the counters.
package bcd_seq_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Width that holds the largest possible digit sum.
   function automatic int sum_width(input int digits, input int digit_w);
      return $clog2(digits * (2**digit_w - 1) + 1);
   endfunction

   // Width of a counter that reaches n; kept at least 1 bit so n=0 still builds.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/bcd_seq_sender_if.sv
// Bus between the sequence requester (master) and the BCD sender (slave).
interface bcd_seq_sender_if #(
   parameter int DIGITS  = 4,
   parameter int DIGIT_W = 4
);
   logic                        start;
   logic [DIGITS*DIGIT_W-1:0]   seqIn;
   logic [DIGIT_W-1:0]          dataIn;
   logic                        digitValid;
   logic                        lastDigit;
   logic                        busy;
   logic                        done;
   logic                        expOdd;
   logic                        err;

   modport master (
      output start, seqIn,
      input  dataIn, digitValid, lastDigit, busy, done, expOdd, err
   );

   modport slave (
      input  start, seqIn,
      output dataIn, digitValid, lastDigit, busy, done, expOdd, err
   );
endinterface

// File: rtl/bcd_seq_shifter.sv
// Parallel-load, left-shift digit register; the top digit is the one on air.
// Zeros shift in from the right, so the top digit is 0 once all digits are out.
module bcd_seq_shifter #(
   parameter int DIGITS  = 4,
   parameter int DIGIT_W = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      load,
   input  logic                      shift,
   input  logic [DIGITS*DIGIT_W-1:0] load_val,
   output logic [DIGIT_W-1:0]        top_digit
);
   localparam int W = DIGITS * DIGIT_W;

   logic [W-1:0] sh_q, sh_d;

   // Load has priority over shift.
   always_comb begin
      sh_d = sh_q;
      if (load)
         sh_d = load_val;
      else if (shift)
         sh_d = sh_q << DIGIT_W;
   end

   // Shift register state.
   always_ff @(posedge CLK) begin
      if (RST)
         sh_q <= '0;
      else
         sh_q <= sh_d;
   end

   assign top_digit = sh_q[W-1 -: DIGIT_W];
endmodule

// File: rtl/bcd_seq_sender.sv
// BCD sequence sender: captures a packed code on start and sends it one digit
// per clock, MSD first, with valid/last framing, an idle gap and the expected
// odd-sum flag. Optional build macro BCD_CHECK_EN rejects starts whose code
// holds a non-BCD digit and pulses err instead.
//
// state  | meaning
// S_IDLE | waiting for start; only state where start is sampled
// S_SEND | one digit on dataIn per cycle
// S_GAP  | forced idle cycles before the next start is accepted
module bcd_seq_sender
   import bcd_seq_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int DIGIT_W    = 4,
   parameter int GAP_CYCLES = 2
) (
   input logic              CLK,
   input logic              RST,
   bcd_seq_sender_if.slave  bus
);
   localparam int SW = sum_width(DIGITS, DIGIT_W);
   localparam int DW = cnt_width(DIGITS);
   localparam int GW = cnt_width(GAP_CYCLES);
   localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   logic [1:0]         state_q, state_d;
   logic [DW-1:0]      cnt_q, cnt_d;
   logic [GW-1:0]      gap_q, gap_d;
   logic [SW-1:0]      sum_q, sum_d;
   logic               valid_q, valid_d;
   logic               last_q, last_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               exp_odd_q, exp_odd_d;
   logic               load, shift;
   logic [DIGIT_W-1:0] digit;

`ifdef BCD_CHECK_EN
   logic bad_code;
   logic err_q, err_d;

   // Flag any digit of the presented code above 9.
   always_comb begin
      bad_code = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (bus.seqIn[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX))
            bad_code = 1'b1;
   end
`endif

   bcd_seq_shifter #(
      .DIGITS  (DIGITS),
      .DIGIT_W (DIGIT_W)
   ) u_shifter (
      .CLK       (CLK),
      .RST       (RST),
      .load      (load),
      .shift     (shift),
      .load_val  (bus.seqIn),
      .top_digit (digit)
   );

   // Next-state, counters, digit sum and framing flags.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      sum_d     = sum_q;
      exp_odd_d = exp_odd_q;
      done_d    = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
`ifdef BCD_CHECK_EN
      err_d     = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
`ifdef BCD_CHECK_EN
               if (bad_code) begin
                  err_d = 1'b1;
               end else
`endif
               begin
                  load      = 1'b1;
                  state_d   = S_SEND;
                  cnt_d     = '0;
                  sum_d     = '0;
                  exp_odd_d = 1'b0;
               end
            end
         end
         S_SEND: begin
            shift = 1'b1;
            sum_d = sum_q + SW'(digit);
            if (cnt_q == DIGIT_LAST) begin
               done_d    = 1'b1;
               exp_odd_d = sum_d[0];
               gap_d     = '0;
               state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST)
               state_d = S_IDLE;
            else
               gap_d = gap_q + GW'(1);
         end
         default: state_d = S_IDLE;
      endcase
      valid_d = (state_d == S_SEND);
      last_d  = valid_d && (cnt_d == DIGIT_LAST);
      busy_d  = (state_d != S_IDLE);
   end

   // Registered state and outputs; reset discards any partial sequence.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         gap_q     <= '0;
         sum_q     <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         exp_odd_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         sum_q     <= sum_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         exp_odd_q <= exp_odd_d;
      end
   end

`ifdef BCD_CHECK_EN
   // Reject pulse for a non-BCD start.
   always_ff @(posedge CLK) begin
      if (RST)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.dataIn     = digit;
   assign bus.digitValid = valid_q;
   assign bus.lastDigit  = last_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.expOdd     = exp_odd_q;
endmodule

// File: tb/tb_bcd_seq_sender.sv
// Scoreboard bench for bcd_seq_sender: one instance with a 2-cycle gap and
// one with no gap. Stimulus pushes cycle-stamped expected digits and done
// flags; per-instance monitors pop and compare on the falling edge.
module tb_bcd_seq_sender;
   localparam int DIGITS  = 4;
   localparam int DIGIT_W = 4;
   localparam int GAP     = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bcd_seq_sender_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) bus  ();
   bcd_seq_sender_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) bus0 ();

   bcd_seq_sender #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .GAP_CYCLES(GAP)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.slave)
   );

   bcd_seq_sender #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .GAP_CYCLES(0)) dut_g0 (
      .CLK (clk),
      .RST (rst),
      .bus (bus0.slave)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct { int cyc; logic [3:0] dig; logic last; } dexp_t;
   typedef struct { int cyc; logic odd; } oexp_t;

   dexp_t qd[$];
   dexp_t qd0[$];
   oexp_t qo[$];
   oexp_t qo0[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected digits of a sequence captured at the edge closing cycle c.
   task automatic push_seq(input bit g0, input int c, input logic [15:0] seq,
                           input bit odd, input int ndig, input bit with_done);
      dexp_t e;
      oexp_t o;
      for (int i = 0; i < ndig; i++) begin
         e.cyc  = c + 1 + i;
         e.dig  = seq[15-4*i -: 4];
         e.last = (i == DIGITS - 1);
         if (g0) qd0.push_back(e); else qd.push_back(e);
      end
      if (with_done) begin
         o.cyc = c + 1 + DIGITS;
         o.odd = odd;
         if (g0) qo0.push_back(o); else qo.push_back(o);
      end
   endtask

   // Monitor for the gap=2 instance.
   always @(negedge clk) begin
      dexp_t e;
      oexp_t o;
      if (bus.digitValid) begin
         if (qd.size() == 0) chk("g2_digit_queue_nonempty", 32'(qd.size()), 32'd1);
         else begin
            e = qd.pop_front();
            chk("g2_digit_cycle", 32'(cyc), 32'(e.cyc));
            chk("g2_digit_value", 32'(bus.dataIn), 32'(e.dig));
            chk("g2_last_digit",  32'(bus.lastDigit), 32'(e.last));
         end
      end else begin
         chk("g2_idle_data_zero", {27'd0, bus.dataIn, bus.lastDigit}, 32'd0);
      end
      if (bus.done) begin
         if (qo.size() == 0) chk("g2_done_queue_nonempty", 32'(qo.size()), 32'd1);
         else begin
            o = qo.pop_front();
            chk("g2_done_cycle", 32'(cyc), 32'(o.cyc));
            chk("g2_exp_odd",    32'(bus.expOdd), 32'(o.odd));
         end
      end
   end

   // Monitor for the gap=0 instance.
   always @(negedge clk) begin
      dexp_t e;
      oexp_t o;
      if (bus0.digitValid) begin
         if (qd0.size() == 0) chk("g0_digit_queue_nonempty", 32'(qd0.size()), 32'd1);
         else begin
            e = qd0.pop_front();
            chk("g0_digit_cycle", 32'(cyc), 32'(e.cyc));
            chk("g0_digit_value", 32'(bus0.dataIn), 32'(e.dig));
            chk("g0_last_digit",  32'(bus0.lastDigit), 32'(e.last));
         end
      end else begin
         chk("g0_idle_data_zero", {27'd0, bus0.dataIn, bus0.lastDigit}, 32'd0);
      end
      if (bus0.done) begin
         if (qo0.size() == 0) chk("g0_done_queue_nonempty", 32'(qo0.size()), 32'd1);
         else begin
            o = qo0.pop_front();
            chk("g0_done_cycle", 32'(cyc), 32'(o.cyc));
            chk("g0_exp_odd",    32'(bus0.expOdd), 32'(o.odd));
         end
      end
   end

   // Single start pulse on the gap=2 instance, then wait for it to finish.
   task automatic run(input logic [15:0] seq, input bit odd);
      int c;
      c = cyc;
      bus.start = 1'b1;
      bus.seqIn = seq;
      push_seq(0, c, seq, odd, DIGITS, 1);
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_capture", 32'(bus.busy), 32'd1);
      repeat (DIGITS + GAP + 2) @(negedge clk);
   endtask

   initial begin
      int c;
      int t;
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.seqIn  = '0;
      bus0.start = 1'b0;
      bus0.seqIn = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs_g2", {22'd0, bus.dataIn, bus.digitValid, bus.lastDigit,
                               bus.busy, bus.done, bus.expOdd, bus.err}, 32'd0);
      chk("reset_outputs_g0", {22'd0, bus0.dataIn, bus0.digitValid, bus0.lastDigit,
                               bus0.busy, bus0.done, bus0.expOdd, bus0.err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic sequences: sums 7, 10, 0.
      run(16'h0025, 1'b1);
      run(16'h1234, 1'b0);
      run(16'h0000, 1'b0);

      // Start held high: second capture only once back in IDLE.
      c = cyc;
      bus.start = 1'b1;
      bus.seqIn = 16'h1234;
      push_seq(0, c,     16'h1234, 1'b0, DIGITS, 1);
      push_seq(0, c + 7, 16'h1234, 1'b0, DIGITS, 1);
      repeat (6) @(negedge clk);
      chk("busy_last_gap_cycle", 32'(bus.busy), 32'd1);
      @(negedge clk);
      chk("busy_low_in_idle", 32'(bus.busy), 32'd0);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (DIGITS + GAP + 4) @(negedge clk);

      // Reset while digit 2 is on dataIn.
      c = cyc;
      bus.start = 1'b1;
      bus.seqIn = 16'h1234;
      push_seq(0, c, 16'h1234, 1'b0, 2, 0);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_seq_reset_outputs", {22'd0, bus.dataIn, bus.digitValid, bus.lastDigit,
                                    bus.busy, bus.done, bus.expOdd, bus.err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      run(16'h0025, 1'b1);

      // Non-BCD digit.
`ifdef BCD_CHECK_EN
      bus.start = 1'b1;
      bus.seqIn = 16'h00A5;
      @(negedge clk);
      bus.start = 1'b0;
      chk("reject_err_pulse", 32'(bus.err), 32'd1);
      chk("reject_busy_low",  32'(bus.busy), 32'd0);
      @(negedge clk);
      chk("reject_err_one_cycle", 32'(bus.err), 32'd0);
      repeat (DIGITS + 2) @(negedge clk);
`else
      run(16'h00A5, 1'b1);
      chk("err_tied_low", 32'(bus.err), 32'd0);
`endif

      // Gap-less instance, start held: one non-valid cycle between sequences.
      c = cyc;
      bus0.start = 1'b1;
      bus0.seqIn = 16'h1234;
      push_seq(1, c,     16'h1234, 1'b0, DIGITS, 1);
      push_seq(1, c + 5, 16'h0025, 1'b1, DIGITS, 1);
      @(negedge clk);
      bus0.seqIn = 16'h0025;
      repeat (4) @(negedge clk);
      chk("g0_single_gap_not_valid", 32'(bus0.digitValid), 32'd0);
      chk("g0_single_gap_busy_low",  32'(bus0.busy), 32'd0);
      @(negedge clk);
      bus0.start = 1'b0;
      repeat (DIGITS + 4) @(negedge clk);

      t = 0;
      while ((qd.size() + qo.size() + qd0.size() + qo0.size()) != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("queues_drained", 32'(qd.size() + qo.size() + qd0.size() + qo0.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
